// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle 16-bit core: opcodes, field
// positions, ROM geometry and small instruction-encoding helpers.
package cpu_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_N     = 8;
    localparam int PC_W      = 5;
    localparam int ROM_DEPTH = 32;
    localparam int ROM_W     = 24;

    localparam int OP_HI  = 23;
    localparam int OP_LO  = 20;
    localparam int RD_HI  = 19;
    localparam int RD_LO  = 17;
    localparam int RA_HI  = 16;
    localparam int RA_LO  = 14;
    localparam int RB_HI  = 13;
    localparam int RB_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int TGT_HI = 4;
    localparam int TGT_LO = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_BEQ  = 4'h9,
        OP_BNE  = 4'hA,
        OP_JMP  = 4'hB,
        OP_HALT = 4'hF
    } opcode_e;

    function automatic logic [ROM_W-1:0] enc_r(input opcode_e op, input logic [2:0] rd,
                                               input logic [2:0] ra, input logic [2:0] rb);
        logic [ROM_W-1:0] w;
        w = '0;
        w[OP_HI:OP_LO] = op;
        w[RD_HI:RD_LO] = rd;
        w[RA_HI:RA_LO] = ra;
        w[RB_HI:RB_LO] = rb;
        return w;
    endfunction

    // imm16 overlaps the ra/rb fields, so immediate forms carry no ra/rb
    function automatic logic [ROM_W-1:0] enc_i(input opcode_e op, input logic [2:0] rd,
                                               input logic [DATA_W-1:0] imm);
        logic [ROM_W-1:0] w;
        w = '0;
        w[OP_HI:OP_LO]   = op;
        w[RD_HI:RD_LO]   = rd;
        w[IMM_HI:IMM_LO] = imm;
        return w;
    endfunction

    function automatic logic [ROM_W-1:0] enc_b(input opcode_e op, input logic [2:0] ra,
                                               input logic [2:0] rb, input logic [PC_W-1:0] tgt);
        logic [ROM_W-1:0] w;
        w = '0;
        w[OP_HI:OP_LO]   = op;
        w[RA_HI:RA_LO]   = ra;
        w[RB_HI:RB_LO]   = rb;
        w[TGT_HI:TGT_LO] = tgt;
        return w;
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the register-register ops; modulo-2^16, no flags.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Single-cycle core: one ROM instruction per rising edge, eight-entry
// register file with hardwired R0, and a result register driving DATA_O.
module cpu_core
    import cpu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DATA_I,
    output logic [DATA_W-1:0] DATA_O,
    output logic [DATA_W-1:0] ADDR,
    output logic              RD,
    output logic              WR
);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] regs_q [REG_N];
    logic [DATA_W-1:0] data_q, data_d;
    logic [ROM_W-1:0]  instr;
    logic [3:0]        op;
    logic [2:0]        rd, ra, rb;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   tgt;
    logic [DATA_W-1:0] ra_val, rb_val, rd_val, alu_y, res;
    logic              wr_en;

    function automatic logic [ROM_W-1:0] rom_word(input logic [PC_W-1:0] a);
        case (a)
            5'd0:    rom_word = enc_i(OP_LDI, 3'd1, 16'd32766);
            5'd1:    rom_word = enc_i(OP_LDI, 3'd2, 16'd1);
            5'd2:    rom_word = enc_i(OP_LDI, 3'd3, 16'd100);
            5'd3:    rom_word = enc_i(OP_LDI, 3'd4, 16'd105);
            5'd4:    rom_word = enc_i(OP_LDI, 3'd5, 16'd200);
            5'd18:   rom_word = enc_r(OP_ADD, 3'd6, 3'd1, 3'd2);
            5'd19:   rom_word = enc_r(OP_SUB, 3'd6, 3'd6, 3'd1);
            5'd20:   rom_word = enc_r(OP_SUB, 3'd7, 3'd0, 3'd2);
            5'd21:   rom_word = enc_r(OP_ADD, 3'd7, 3'd2, 3'd0);
            5'd22:   rom_word = enc_r(OP_ADD, 3'd7, 3'd5, 3'd0);
            5'd24:   rom_word = enc_r(OP_ADD, 3'd6, 3'd3, 3'd0);
            5'd27:   rom_word = enc_r(OP_ADD, 3'd6, 3'd6, 3'd2);
            5'd28:   rom_word = enc_b(OP_BNE, 3'd6, 3'd4, 5'd26);
            5'd30:   rom_word = enc_r(OP_ADD, 3'd7, 3'd5, 3'd0);
            5'd31:   rom_word = enc_r(OP_HALT, 3'd0, 3'd0, 3'd0);
            default: rom_word = '0;
        endcase
    endfunction

    assign instr = rom_word(pc_q);
    assign op    = instr[OP_HI:OP_LO];
    assign rd    = instr[RD_HI:RD_LO];
    assign ra    = instr[RA_HI:RA_LO];
    assign rb    = instr[RB_HI:RB_LO];
    assign imm   = instr[IMM_HI:IMM_LO];
    assign tgt   = instr[TGT_HI:TGT_LO];

    assign ra_val = (ra == 3'd0) ? '0 : regs_q[ra];
    assign rb_val = (rb == 3'd0) ? '0 : regs_q[rb];
    assign rd_val = (rd == 3'd0) ? '0 : regs_q[rd];

    cpu_alu u_alu (
        .op_i (op),
        .a_i  (ra_val),
        .b_i  (rb_val),
        .y_o  (alu_y)
    );

    always_comb begin
        pc_d   = pc_q + 1'b1;
        wr_en  = 1'b0;
        res    = '0;
        data_d = data_q;
        case (op)
            OP_LDI: begin
                wr_en = 1'b1;
                res   = imm;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                wr_en = 1'b1;
                res   = alu_y;
            end
            OP_LD: begin
                wr_en = 1'b1;
                res   = DATA_I;
            end
            OP_BEQ:  if (ra_val == rb_val) pc_d = tgt;
            OP_BNE:  if (ra_val != rb_val) pc_d = tgt;
            OP_JMP:  pc_d = tgt;
            OP_HALT: pc_d = pc_q;
            default: ;
        endcase
        if (wr_en) data_d = res;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q   <= '0;
            data_q <= '0;
            for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            data_q <= data_d;
            if (wr_en && rd != 3'd0) regs_q[rd] <= res;
        end
    end

    // Bus strobes follow the current instruction; reset forces them idle.
    assign RD     = RST && (op == OP_LD);
    assign WR     = RST && (op == OP_ST);
    assign ADDR   = (RD || WR) ? imm : '0;
    assign DATA_O = !RST ? '0 : (op == OP_ST) ? rd_val : data_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: walks the ROM program edge by edge against
// a hand-written DATA_O timeline, then checks DATA_I isolation and reset.
module tb_cpu_core;

    logic        CLK;
    logic        RST;
    logic [15:0] DATA_I;
    logic [15:0] DATA_O;
    logic [15:0] ADDR;
    logic        RD;
    logic        WR;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q [0:60];

    cpu_core dut (
        .CLK    (CLK),
        .RST    (RST),
        .DATA_I (DATA_I),
        .DATA_O (DATA_O),
        .ADDR   (ADDR),
        .RD     (RD),
        .WR     (WR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    endtask

    // Hand-derived DATA_O after each edge; unlisted edges hold the prior value.
    task automatic build_table();
        int ev [][2];
        ev = '{'{1, 32766}, '{2, 1}, '{3, 100}, '{4, 105}, '{5, 200},
               '{19, 32767}, '{20, 1}, '{21, 65535}, '{22, 1}, '{23, 200},
               '{25, 100}, '{28, 101}, '{31, 102}, '{34, 103}, '{37, 104},
               '{40, 105}, '{43, 200}};
        exp_q[0] = 0;
        for (int e = 1; e <= 60; e++) begin
            exp_q[e] = exp_q[e-1];
            foreach (ev[k]) if (ev[k][0] == e) exp_q[e] = ev[k][1];
        end
    endtask

    task automatic run_edges(input int n, input bool_isolate);
        string tag;
        for (int e = 1; e <= n; e++) begin
            if (bool_isolate && e == 38) DATA_I = 16'd26;
            @(posedge CLK);
            #1;
            tag = $sformatf("data_e%0d", e);
            chk(tag, {16'd0, DATA_O}, exp_q[e]);
            tag = $sformatf("bus_e%0d", e);
            chk(tag, {14'd0, RD, WR, ADDR}, 32'd0);
        end
    endtask

    initial begin
        build_table();
        RST    = 1'b0;
        DATA_I = 16'h1234;
        #12;
        chk("rst_data", {16'd0, DATA_O}, 32'd0);
        chk("rst_bus", {14'd0, RD, WR, ADDR}, 32'd0);

        @(negedge CLK);
        RST = 1'b1;
        run_edges(50, 1);

        // Restart and abort mid-loop with an asynchronous reset pulse.
        RST = 1'b0;
        #1;
        chk("rst2_data", {16'd0, DATA_O}, 32'd0);
        @(negedge CLK);
        RST    = 1'b1;
        DATA_I = 16'hBEEF;
        run_edges(31, 0);
        #1;
        RST = 1'b0;
        #1;
        chk("midrst_data", {16'd0, DATA_O}, 32'd0);
        chk("midrst_bus", {14'd0, RD, WR, ADDR}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        run_edges(3, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
